flags_branch_unit: RTL
======================

// Module: flags_branch_unit
// PURPOSE
//  Consumer side of the ALU status interface: latches the Z/N/V/C flags the ALU produces, evaluates
//  conditional-branch opcodes against them and issues a PC redirect plus pipeline flush to fetch.
//  Sits between the ALU/execute stage and the PC/fetch logic of the fdt16 core.
// PARAMETERS
//  DATA_W        16  width of branch target / PC
//  OPC_W         6   opcode width (ALU and branch opcodes share this encoding space)
//  FLUSH_CYCLES  2   cycles flush stays high after a taken redirect (1..7)
// PORTS
//  clk            in   1       core clock, rising edge
//  rst            in   1       synchronous, active-high reset
//  alu_valid      in   1       ALU result/flags valid this cycle
//  alu_opcode     in   OPC_W   opcode the ALU executed
//  alu_store      in   1       ALU store cycle; no flag update when high
//  alu_zero/alu_negative/alu_overflow/alu_carry  in 1 each  ALU flag outputs
//  br_valid       in   1       branch instruction presented
//  br_ready       out  1       unit can accept a branch this cycle
//  br_opcode      in   OPC_W   branch opcode
//  br_target      in   DATA_W  branch destination address
//  flags_save     in   1       copy live flags into shadow register (interrupt entry)
//  flags_restore  in   1       copy shadow into live flags (interrupt return)
//  flags          out  4       live flags {Z,N,V,C}
//  pc_load        out  1       one-cycle pulse: load pc_target into PC
//  pc_target      out  DATA_W  redirect address, valid while pc_load=1
//  flush          out  1       squash fetched/decoded instructions
//  br_taken_cnt   out  16      count of taken branches, wraps at 0xFFFF->0
// BEHAVIOUR
//  Reset: flags=0, shadow=0, pc_load=0, pc_target=0, flush=0, br_ready=1, br_taken_cnt=0, state=IDLE.
//  Flag update (clock edge, alu_valid=1, alu_store=0):
//   - ADD..DEC (6'b010001-6'b011001, incl. CMP/TEST): all four flags loaded.
//   - shifts/logic/MOV (6'b000111, 6'b001000-6'b001110): Z,N loaded; V,C preserved.
//   - NOP and any other opcode: flags unchanged.
//  Priority: flags_restore > ALU update; flags_save captures pre-edge live flags, same cycle as restore allowed
//   (shadow gets old live value, live gets old shadow = swap).
//  Branch opcodes: 100000 BRA(1) 100001 BEQ(Z) 100010 BNE(!Z) 100011 BMI(N) 100100 BPL(!N)
//   100101 BVS(V) 100110 BCS(C) 100111 BCC(!C) 101000 BGT(!Z & N==V) 101001 BLT(N!=V);
//   any other br_opcode with br_valid: not taken, no error.
//  Forwarding: if alu_valid and br_valid in same cycle, condition uses flags as they will be after this edge
//   (restore/update rules applied); otherwise registered flags.
//  Handshake: branch accepted on edge where br_valid & br_ready. br_ready=1 only in IDLE.
//  FSM: IDLE -accepted & taken-> REDIRECT; IDLE -not taken-> IDLE (no outputs).
//   REDIRECT (1 cycle): pc_load=1, pc_target=latched br_target, flush=1, br_taken_cnt+=1 -> FLUSH.
//   FLUSH: flush=1 for FLUSH_CYCLES-1 further cycles (counter) -> IDLE. FLUSH_CYCLES=1 skips FLUSH.
//  Latency: accept edge -> pc_load high next cycle (1 cycle). Total flush high = FLUSH_CYCLES cycles.
//  Flags keep updating from ALU during REDIRECT/FLUSH (ALU of squashed ops is gated upstream).
//  br_valid while br_ready=0: ignored, not latched; sender must hold.
//  rst mid-REDIRECT/FLUSH: all outputs to reset values next edge; no redirect survives.
// TESTING
//  1 rst, ALU SUB 5-5 (Z=1,N=0,V=0,C=1) then BEQ target 16'h0040 -> pc_load one cycle after accept, pc_target=16'h0040, flush high 2 cycles, br_ready low 2 cycles.
//  2 ALU ADD sets C=1,V=1 then AND result 0x8000 -> flags={0,1,1,1}; then NOP -> unchanged; alu_store=1 ADD -> unchanged.
//  3 Same-cycle ALU CMP 3,3 and BNE 16'h0100 -> forwarded Z=1, not taken, no pc_load, br_ready stays 1.
//  4 Flags {1,0,0,1}, flags_save; CMP changes to {0,1,0,0}; flags_restore -> flags={1,0,0,1}; save+restore same cycle -> swap.
//  5 BLT with N=1,V=0 -> taken; during FLUSH present BRA -> ignored until br_ready=1, then accepted; br_taken_cnt=2.
//  6 rst asserted in REDIRECT -> pc_load,flush=0, br_ready=1, br_taken_cnt=0 next cycle; preset cnt 0xFFFF + taken -> 0.

Source files
------------

// File: rtl/flags_branch_unit.sv
// Latches ALU Z/N/V/C flags (with an interrupt shadow copy) and resolves conditional branches,
// issuing a one-cycle PC load followed by a fixed-length pipeline flush on a taken branch.
module flags_branch_unit #(
  parameter int DATA_W       = 16,
  parameter int OPC_W        = 6,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [OPC_W-1:0]  alu_opcode,
  input  logic              alu_store,
  input  logic              alu_zero,
  input  logic              alu_negative,
  input  logic              alu_overflow,
  input  logic              alu_carry,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [OPC_W-1:0]  br_opcode,
  input  logic [DATA_W-1:0] br_target,
  input  logic              flags_save,
  input  logic              flags_restore,
  output logic [3:0]        flags,
  output logic              pc_load,
  output logic [DATA_W-1:0] pc_target,
  output logic              flush,
  output logic [15:0]       br_taken_cnt
);

  typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;

  localparam logic [OPC_W-1:0] ARITH_LO = OPC_W'(6'b010001);
  localparam logic [OPC_W-1:0] ARITH_HI = OPC_W'(6'b011001);
  localparam logic [OPC_W-1:0] SHIFT_OP = OPC_W'(6'b000111);
  localparam logic [OPC_W-1:0] LOGIC_LO = OPC_W'(6'b001000);
  localparam logic [OPC_W-1:0] LOGIC_HI = OPC_W'(6'b001110);

  localparam logic [OPC_W-1:0] BRA = OPC_W'(6'b100000);
  localparam logic [OPC_W-1:0] BEQ = OPC_W'(6'b100001);
  localparam logic [OPC_W-1:0] BNE = OPC_W'(6'b100010);
  localparam logic [OPC_W-1:0] BMI = OPC_W'(6'b100011);
  localparam logic [OPC_W-1:0] BPL = OPC_W'(6'b100100);
  localparam logic [OPC_W-1:0] BVS = OPC_W'(6'b100101);
  localparam logic [OPC_W-1:0] BCS = OPC_W'(6'b100110);
  localparam logic [OPC_W-1:0] BCC = OPC_W'(6'b100111);
  localparam logic [OPC_W-1:0] BGT = OPC_W'(6'b101000);
  localparam logic [OPC_W-1:0] BLT = OPC_W'(6'b101001);

  // FLUSH state covers FLUSH_CYCLES-1 cycles; the counter runs down to zero.
  localparam logic [2:0] FLUSH_INIT = 3'((FLUSH_CYCLES > 1) ? (FLUSH_CYCLES - 2) : 0);

  state_t              state_q, state_d;
  logic [3:0]          flags_q, flags_d;
  logic [3:0]          shadow_q, shadow_d;
  logic [DATA_W-1:0]   target_q, target_d;
  logic [2:0]          fcnt_q, fcnt_d;
  logic [15:0]         cnt_q, cnt_d;

  logic                is_arith, is_logic;
  logic [3:0]          eval_flags;
  logic                cond_true;

  assign is_arith = (alu_opcode >= ARITH_LO) && (alu_opcode <= ARITH_HI);
  assign is_logic = (alu_opcode == SHIFT_OP) ||
                    ((alu_opcode >= LOGIC_LO) && (alu_opcode <= LOGIC_HI));

  always_comb begin
    flags_d  = flags_q;
    shadow_d = shadow_q;
    if (flags_save) begin
      shadow_d = flags_q;
    end
    if (flags_restore) begin
      flags_d = shadow_q;
    end else if (alu_valid && !alu_store) begin
      if (is_arith) begin
        flags_d = {alu_zero, alu_negative, alu_overflow, alu_carry};
      end else if (is_logic) begin
        flags_d = {alu_zero, alu_negative, flags_q[1:0]};
      end
    end
  end

  // A branch paired with a live ALU result sees the flags as they will be after this edge.
  assign eval_flags = (alu_valid && br_valid) ? flags_d : flags_q;

  always_comb begin
    cond_true = 1'b0;
    unique case (br_opcode)
      BRA:     cond_true = 1'b1;
      BEQ:     cond_true = eval_flags[3];
      BNE:     cond_true = !eval_flags[3];
      BMI:     cond_true = eval_flags[2];
      BPL:     cond_true = !eval_flags[2];
      BVS:     cond_true = eval_flags[1];
      BCS:     cond_true = eval_flags[0];
      BCC:     cond_true = !eval_flags[0];
      BGT:     cond_true = !eval_flags[3] && (eval_flags[2] == eval_flags[1]);
      BLT:     cond_true = eval_flags[2] != eval_flags[1];
      default: cond_true = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    fcnt_d   = fcnt_q;
    cnt_d    = cnt_q;
    br_ready = 1'b0;
    pc_load  = 1'b0;
    flush    = 1'b0;
    unique case (state_q)
      IDLE: begin
        br_ready = 1'b1;
        if (br_valid && cond_true) begin
          target_d = br_target;
          state_d  = REDIRECT;
        end
      end
      REDIRECT: begin
        pc_load = 1'b1;
        flush   = 1'b1;
        cnt_d   = 16'(cnt_q + 16'd1);
        fcnt_d  = FLUSH_INIT;
        state_d = (FLUSH_CYCLES > 1) ? FLUSH : IDLE;
      end
      FLUSH: begin
        flush = 1'b1;
        if (fcnt_q == 3'd0) begin
          state_d = IDLE;
        end else begin
          fcnt_d = fcnt_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      flags_q  <= 4'b0;
      shadow_q <= 4'b0;
      target_q <= '0;
      fcnt_q   <= 3'd0;
      cnt_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      flags_q  <= flags_d;
      shadow_q <= shadow_d;
      target_q <= target_d;
      fcnt_q   <= fcnt_d;
      cnt_q    <= cnt_d;
    end
  end

  assign flags        = flags_q;
  assign pc_target    = target_q;
  assign br_taken_cnt = cnt_q;

endmodule
